uart_cmd_ctrl: RTL

Command controller that sits behind UART_rx. It turns received ASCII bytes into single-cycle control pulses for the clock and stopwatch datapaths, and into a validated time-set load.
- It sequences multi-byte set-time commands and enforces an inter-byte timeout.
- It returns a one-byte acknowledge to the UART transmit path through a valid/ready handshake.

---
 rtl/uart_cmd_ctrl_pkg.sv | 28 ++
 rtl/uart_cmd_ctrl_if.sv | 30 +++
 rtl/uart_cmd_ctrl_ascii_pair2bin.sv | 18 +
 rtl/uart_cmd_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the UART command controller.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] AsciiM        = 8'h4D;
  localparam logic [7:0] AsciiR        = 8'h52;
  localparam logic [7:0] AsciiC        = 8'h43;
  localparam logic [7:0] AsciiS        = 8'h53;
  localparam logic [7:0] AsciiCr       = 8'h0D;
  localparam logic [7:0] AsciiLf       = 8'h0A;
  localparam logic [7:0] AsciiZero     = 8'h30;
  localparam logic [7:0] AsciiNine     = 8'h39;
  localparam logic [7:0] CaseMask      = 8'hDF;
  localparam logic [7:0] AckOkDefault  = 8'h4B;
  localparam logic [7:0] AckErrDefault = 8'h3F;

  localparam int unsigned NumDigits = 6;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCheck
  } state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= AsciiZero) && (b <= AsciiNine);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Receive, command-pulse, time-set and acknowledge signals of the command controller.
interface uart_cmd_ctrl_if;

  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       o_mode_toggle;
  logic       o_sw_run_toggle;
  logic       o_sw_clear;
  logic       o_set_time;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min;
  logic [5:0] o_set_sec;
  logic       o_cmd_busy;
  logic       o_ack_valid;
  logic [7:0] o_ack_data;
  logic       i_ack_ready;

  modport slave (
    input  i_rx_data, i_rx_done, i_ack_ready,
    output o_mode_toggle, o_sw_run_toggle, o_sw_clear, o_set_time,
    output o_set_hour, o_set_min, o_set_sec, o_cmd_busy, o_ack_valid, o_ack_data
  );

  modport master (
    output i_rx_data, i_rx_done, i_ack_ready,
    input  o_mode_toggle, o_sw_run_toggle, o_sw_clear, o_set_time,
    input  o_set_hour, o_set_min, o_set_sec, o_cmd_busy, o_ack_valid, o_ack_data
  );

endinterface

// File: rtl/uart_cmd_ctrl_ascii_pair2bin.sv
// Converts two ASCII decimal digits to binary and checks the result against a limit.
module uart_cmd_ctrl_ascii_pair2bin
  import uart_cmd_ctrl_pkg::*;
(
  input  logic [7:0] tens,
  input  logic [7:0] units,
  input  logic [6:0] limit,
  output logic [6:0] value,
  output logic       ok
);

  // Inputs are already known to be '0'-'9', so the low bits hold the digit value.
  always_comb begin
    value = 7'(tens - AsciiZero) * 7'd10 + 7'(units - AsciiZero);
    ok    = (value <= limit);
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART bytes into control pulses and a validated set-time load, with a one-byte ack.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter logic [7:0]  ACK_OK         = AckOkDefault,
  parameter logic [7:0]  ACK_ERR        = AckErrDefault
) (
  input  logic            clk,
  input  logic            reset,
  uart_cmd_ctrl_if.slave  bus
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e                       state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [NumDigits-1:0][7:0]    digits_q, digits_d;
  logic [TmoW-1:0]              tmo_q, tmo_d;
  logic                         rx_done_q;
  logic                         mode_q, mode_d;
  logic                         run_q, run_d;
  logic                         clr_q, clr_d;
  logic                         set_q, set_d;
  logic [4:0]                   hour_q, hour_d;
  logic [5:0]                   min_q, min_d;
  logic [5:0]                   sec_q, sec_d;
  logic                         ack_valid_q, ack_valid_d;
  logic [7:0]                   ack_data_q, ack_data_d;

  logic       ev;
  logic [7:0] rx;
  logic [7:0] rx_up;
  logic       ack_new;
  logic [7:0] ack_byte;
  logic [6:0] hour_v, min_v, sec_v;
  logic       hour_ok, min_ok, sec_ok;

  assign ev    = bus.i_rx_done & ~rx_done_q;
  assign rx    = bus.i_rx_data;
  assign rx_up = bus.i_rx_data & CaseMask;

  // Digits stored as h1 h0 m1 m0 s1 s0 in indices 0..5.
  uart_cmd_ctrl_ascii_pair2bin u_hour (
    .tens  (digits_q[0]),
    .units (digits_q[1]),
    .limit (7'd23),
    .value (hour_v),
    .ok    (hour_ok)
  );

  uart_cmd_ctrl_ascii_pair2bin u_min (
    .tens  (digits_q[2]),
    .units (digits_q[3]),
    .limit (7'd59),
    .value (min_v),
    .ok    (min_ok)
  );

  uart_cmd_ctrl_ascii_pair2bin u_sec (
    .tens  (digits_q[4]),
    .units (digits_q[5]),
    .limit (7'd59),
    .value (sec_v),
    .ok    (sec_ok)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    tmo_d    = tmo_q;
    mode_d   = 1'b0;
    run_d    = 1'b0;
    clr_d    = 1'b0;
    set_d    = 1'b0;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    ack_new  = 1'b0;
    ack_byte = ACK_ERR;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (ev) begin
          // CR/LF compared raw: masking would alias '-' (0x2D) onto CR.
          if (rx == AsciiCr || rx == AsciiLf) begin
            ack_new = 1'b0;
          end else if (rx_up == AsciiM) begin
            mode_d   = 1'b1;
            ack_new  = 1'b1;
            ack_byte = ACK_OK;
          end else if (rx_up == AsciiR) begin
            run_d    = 1'b1;
            ack_new  = 1'b1;
            ack_byte = ACK_OK;
          end else if (rx_up == AsciiC) begin
            clr_d    = 1'b1;
            ack_new  = 1'b1;
            ack_byte = ACK_OK;
          end else if (rx_up == AsciiS) begin
            state_d = StCollect;
            cnt_d   = '0;
          end else begin
            ack_new = 1'b1;
          end
        end
      end

      StCollect: begin
        if (ev) begin
          tmo_d = '0;
          if (is_digit(rx)) begin
            digits_d[cnt_q] = rx;
            if (cnt_q == 3'(NumDigits - 1)) begin
              state_d = StCheck;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            ack_new = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (tmo_q == TmoLast) begin
          ack_new = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (tmo_q != {TmoW{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StCheck: begin
        ack_new = 1'b1;
        if (hour_ok && min_ok && sec_ok) begin
          set_d    = 1'b1;
          hour_d   = 5'(hour_v);
          min_d    = 6'(min_v);
          sec_d    = 6'(sec_v);
          ack_byte = ACK_OK;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Latest ack wins, even over a same-cycle acceptance.
    ack_valid_d = ack_valid_q;
    ack_data_d  = ack_data_q;
    if (ack_new) begin
      ack_valid_d = 1'b1;
      ack_data_d  = ack_byte;
    end else if (ack_valid_q && bus.i_ack_ready) begin
      ack_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      digits_q    <= '0;
      tmo_q       <= '0;
      rx_done_q   <= 1'b0;
      mode_q      <= 1'b0;
      run_q       <= 1'b0;
      clr_q       <= 1'b0;
      set_q       <= 1'b0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      ack_valid_q <= 1'b0;
      ack_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      tmo_q       <= tmo_d;
      rx_done_q   <= bus.i_rx_done;
      mode_q      <= mode_d;
      run_q       <= run_d;
      clr_q       <= clr_d;
      set_q       <= set_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      ack_valid_q <= ack_valid_d;
      ack_data_q  <= ack_data_d;
    end
  end

  assign bus.o_mode_toggle   = mode_q;
  assign bus.o_sw_run_toggle = run_q;
  assign bus.o_sw_clear      = clr_q;
  assign bus.o_set_time      = set_q;
  assign bus.o_set_hour      = hour_q;
  assign bus.o_set_min       = min_q;
  assign bus.o_set_sec       = sec_q;
  assign bus.o_cmd_busy      = (state_q == StCollect);
  assign bus.o_ack_valid     = ack_valid_q;
  assign bus.o_ack_data      = ack_data_q;

endmodule
